// File: rtl/clk_div_prog_if.sv
// Divisor configuration bus for clk_div_prog: write strobe, channel index, divisor, and pending flags.
interface clk_div_prog_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 16
);
    logic            cfg_wr;
    logic [3:0]      cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic [NCH-1:0]  cfg_pend;

    modport master (output cfg_wr, cfg_ch, cfg_div, input cfg_pend);
    modport slave  (input cfg_wr, cfg_ch, cfg_div, output cfg_pend);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable 50% clock divider with glitch-free shadowed divisor updates.
// Optional per-channel rising-edge tick output is enabled by defining CLK_DIV_PROG_TICK_EN.
module clk_div_prog #(
    parameter int          NCH      = 4,
    parameter int          DIVW     = 16,
    parameter int unsigned DIV_INIT = 32'd3
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    clk_div_prog_if.slave    cfg,
    output logic [NCH-1:0]   outclk,
    output logic [NCH-1:0]   tick
);

    logic [DIVW-1:0] cnt_r     [NCH];
    logic [DIVW-1:0] act_r     [NCH];
    logic [DIVW-1:0] shd_r     [NCH];
    logic [DIVW-1:0] cnt_nxt_s [NCH];
    logic [DIVW-1:0] act_nxt_s [NCH];
    logic [DIVW-1:0] shd_nxt_s [NCH];
    logic [NCH-1:0]  out_r;
    logic [NCH-1:0]  pend_r;
    logic [NCH-1:0]  out_nxt_s;
    logic [NCH-1:0]  pend_nxt_s;
    logic [NCH-1:0]  apply_s;
    logic [NCH-1:0]  wr_hit_s;

    // Next-state logic for every channel's counter, output phase and divisor pair
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt_s[i]  = cnt_r[i];
            out_nxt_s[i]  = out_r[i];
            act_nxt_s[i]  = act_r[i];
            shd_nxt_s[i]  = shd_r[i];
            pend_nxt_s[i] = pend_r[i];
            apply_s[i]    = 1'b0;
            // Indices >= NCH never match because i only spans the implemented channels.
            wr_hit_s[i]   = cfg.cfg_wr && (cfg.cfg_ch == 4'(i));

            if (sync) begin
                cnt_nxt_s[i] = {DIVW{1'b0}};
                out_nxt_s[i] = 1'b0;
                apply_s[i]   = pend_r[i];
            end else if (!en[i]) begin
                cnt_nxt_s[i] = {DIVW{1'b0}};
                out_nxt_s[i] = 1'b0;
                apply_s[i]   = pend_r[i];
            end else if (cnt_r[i] == act_r[i]) begin
                cnt_nxt_s[i] = {DIVW{1'b0}};
                out_nxt_s[i] = ~out_r[i];
                // Only swap divisors when a high half ends, so the new rate starts on a clean low half.
                apply_s[i]   = pend_r[i] & out_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + DIVW'(1);
            end

            if (apply_s[i]) begin
                act_nxt_s[i]  = shd_r[i];
                pend_nxt_s[i] = 1'b0;
            end else begin
                act_nxt_s[i]  = act_r[i];
            end

            // A write landing with an apply keeps the new value pending for the next boundary.
            if (wr_hit_s[i]) begin
                shd_nxt_s[i]  = cfg.cfg_div;
                pend_nxt_s[i] = 1'b1;
            end else begin
                shd_nxt_s[i]  = shd_r[i];
            end
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge mclk) begin
        if (rst) begin
            out_r  <= {NCH{1'b0}};
            pend_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= {DIVW{1'b0}};
                act_r[i] <= DIVW'(DIV_INIT);
                shd_r[i] <= DIVW'(DIV_INIT);
            end
        end else begin
            out_r  <= out_nxt_s;
            pend_r <= pend_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                act_r[i] <= act_nxt_s[i];
                shd_r[i] <= shd_nxt_s[i];
            end
        end
    end

    assign outclk       = out_r;
    assign cfg.cfg_pend = pend_r;

`ifdef CLK_DIV_PROG_TICK_EN
    logic [NCH-1:0] tick_r;

    // Tick register: high in the first cycle each outclk reads 1
    always_ff @(posedge mclk) begin
        if (rst) begin
            tick_r <= {NCH{1'b0}};
        end else begin
            tick_r <= out_nxt_s & ~out_r;
        end
    end

    assign tick = tick_r;
`else
    assign tick = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected outclk edges are queued per channel by the stimulus
// and matched by a monitor that watches every output transition.
module tb_clk_div_prog;

    localparam int NCH  = 4;
    localparam int DIVW = 16;

    typedef struct packed {
        int   cyc_e;
        logic lvl;
    } ev_t;

    logic           mclk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] tick;

    clk_div_prog_if #(.NCH(NCH), .DIVW(DIVW)) cfg_if ();

    clk_div_prog #(.NCH(NCH), .DIVW(DIVW), .DIV_INIT(32'd3)) dut (
        .mclk   (mclk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .cfg    (cfg_if),
        .outclk (outclk),
        .tick   (tick)
    );

    int             cyc   = 0;
    int             tests = 0;
    int             fails = 0;
    logic [NCH-1:0] armed = '0;
    logic [NCH-1:0] prev  = '0;
    ev_t            exp_q [NCH][$];

    initial forever #5 mclk = ~mclk;

    initial forever begin
        @(posedge mclk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_one(input int c, input int t, input logic l);
        ev_t e;
        e.cyc_e = t;
        e.lvl   = l;
        exp_q[c].push_back(e);
    endtask

    task automatic push_edges(input int c, input int t0, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            push_one(c, t0 + 2 * k * (d + 1), 1'b1);
            push_one(c, t0 + 2 * k * (d + 1) + d + 1, 1'b0);
        end
    endtask

    task automatic disarm(input int c);
        armed[c] = 1'b0;
        exp_q[c].delete();
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge mclk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [DIVW-1:0] d);
        cfg_if.cfg_wr  = 1'b1;
        cfg_if.cfg_ch  = ch;
        cfg_if.cfg_div = d;
    endtask

    // Monitor: match each outclk transition against the queue, flag missed edges, check tick
    initial forever begin
        ev_t  e;
        logic tick_exp;
        @(negedge mclk);
        for (int c = 0; c < NCH; c++) begin
            if (armed[c]) begin
                if (outclk[c] !== prev[c]) begin
                    if (exp_q[c].size() == 0) begin
                        tests = tests + 1;
                        fails = fails + 1;
                        $display("FAIL edge_ch%0d: unexpected change to %b at cycle %0d, none required",
                                 c, outclk[c], cyc);
                    end else begin
                        e = exp_q[c].pop_front();
                        tests = tests + 1;
                        if ((e.cyc_e != cyc) || (e.lvl !== outclk[c])) begin
                            fails = fails + 1;
                            $display("FAIL edge_ch%0d: got level %b at cycle %0d, want level %b at cycle %0d",
                                     c, outclk[c], cyc, e.lvl, e.cyc_e);
                        end
                    end
                end else if ((exp_q[c].size() != 0) && (exp_q[c][0].cyc_e <= cyc)) begin
                    e = exp_q[c].pop_front();
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("FAIL edge_ch%0d: level stayed %b at cycle %0d, want change to %b",
                             c, outclk[c], cyc, e.lvl);
                end
            end
`ifdef CLK_DIV_PROG_TICK_EN
            tick_exp = outclk[c] & ~prev[c];
`else
            tick_exp = 1'b0;
`endif
            if (tick_exp || tick[c]) begin
                tests = tests + 1;
                if (tick[c] !== tick_exp) begin
                    fails = fails + 1;
                    $display("FAIL tick_ch%0d: got %b, want %b at cycle %0d", c, tick[c], tick_exp, cyc);
                end
            end
            prev[c] = outclk[c];
        end
    end

    initial begin
        int b;
        int n1;
        int s;
        int t;
        int r;
        rst            = 1'b1;
        en             = 4'h0;
        sync           = 1'b0;
        cfg_if.cfg_wr  = 1'b0;
        cfg_if.cfg_ch  = 4'd0;
        cfg_if.cfg_div = 16'd0;

        goto(3);
        chk("rst_outclk", 32'(outclk), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pend", 32'(cfg_if.cfg_pend), 32'h0);

        // Default divisors, all channels: period 8, first rise on the 4th enabled edge
        b   = cyc;
        rst = 1'b0;
        en  = 4'hF;
        armed = 4'hF;
        push_edges(0, b + 4, 3, 10);
        push_edges(1, b + 4, 3, 4);
        push_edges(2, b + 4, 3, 5);
        push_edges(3, b + 4, 3, 10);
        goto(b + 7);
        chk("duty_high", 32'(outclk), 32'hF);
        goto(b + 8);
        chk("duty_low", 32'(outclk), 32'h0);

        // Out-of-range channel index is ignored
        goto(b + 10);
        cfg_write(4'd4, 16'd0);
        goto(b + 11);
        cfg_if.cfg_wr = 1'b0;
        chk("oob_pend", 32'(cfg_if.cfg_pend), 32'h0);

        // ch1 D=0 written during the high phase applies at the period end
        goto(b + 28);
        cfg_write(4'd1, 16'd0);
        goto(b + 29);
        cfg_if.cfg_wr = 1'b0;
        chk("ch1_pend_set", 32'(cfg_if.cfg_pend), 32'h2);
        push_edges(1, b + 33, 0, 4);
        goto(b + 31);
        chk("ch1_pend_hold", 32'(cfg_if.cfg_pend), 32'h2);
        goto(b + 32);
        chk("ch1_pend_clr", 32'(cfg_if.cfg_pend), 32'h0);

        // ch2: D=5 then D=9 before the boundary, only D=9 applies
        goto(b + 33);
        cfg_write(4'd2, 16'd5);
        goto(b + 35);
        cfg_write(4'd2, 16'd9);
        goto(b + 36);
        cfg_if.cfg_wr = 1'b0;
        chk("ch2_pend_set", 32'(cfg_if.cfg_pend), 32'h4);
        push_edges(2, b + 50, 9, 2);
        goto(b + 39);
        chk("ch2_pend_hold", 32'(cfg_if.cfg_pend), 32'h4);
        goto(b + 40);
        disarm(1);
        chk("ch2_pend_clr", 32'(cfg_if.cfg_pend), 32'h0);
        goto(b + 81);
        for (int c = 0; c < NCH; c++) disarm(c);

        // Disabled channels take new divisors immediately
        n1 = cyc;
        en = 4'h0;
        goto(n1 + 1);
        cfg_write(4'd0, 16'd1);
        goto(n1 + 2);
        chk("dis_pend0", 32'(cfg_if.cfg_pend), 32'h1);
        cfg_write(4'd1, 16'd3);
        goto(n1 + 3);
        chk("dis_pend1", 32'(cfg_if.cfg_pend), 32'h2);
        cfg_write(4'd2, 16'd7);
        goto(n1 + 4);
        chk("dis_pend2", 32'(cfg_if.cfg_pend), 32'h4);
        cfg_if.cfg_wr = 1'b0;
        goto(n1 + 5);
        chk("dis_pend_clr", 32'(cfg_if.cfg_pend), 32'h0);
        goto(n1 + 6);
        en = 4'hF;

        // sync restarts all channels phase-aligned
        s = n1 + 16;
        goto(s - 1);
        sync = 1'b1;
        goto(s);
        sync = 1'b0;
        chk("sync_outclk", 32'(outclk), 32'h0);
        armed = 4'hF;
        push_edges(0, s + 2, 1, 4);
        push_edges(1, s + 4, 3, 2);
        push_edges(2, s + 8, 7, 1);
        push_edges(3, s + 4, 3, 2);
        goto(s + 17);
        for (int c = 0; c < NCH; c++) disarm(c);

        // Pending D=4 applies at sync while D=2 written with sync stays pending
        t = s + 20;
        goto(t - 1);
        sync = 1'b1;
        goto(t);
        sync = 1'b0;
        armed[0] = 1'b1;
        push_edges(0, t + 2, 1, 1);
        push_one(0, t + 6, 1'b1);
        push_one(0, t + 7, 1'b0);
        push_edges(0, t + 12, 4, 1);
        push_edges(0, t + 20, 2, 2);
        goto(t + 4);
        cfg_write(4'd0, 16'd4);
        goto(t + 5);
        cfg_if.cfg_wr = 1'b0;
        chk("e_pend_d4", 32'(cfg_if.cfg_pend), 32'h1);
        goto(t + 6);
        sync = 1'b1;
        cfg_write(4'd0, 16'd2);
        goto(t + 7);
        sync = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        chk("e_sync_out0", 32'(outclk[0]), 32'h0);
        chk("e_pend_d2", 32'(cfg_if.cfg_pend), 32'h1);
        goto(t + 16);
        chk("e_pend_hold", 32'(cfg_if.cfg_pend), 32'h1);
        goto(t + 17);
        chk("e_pend_clr", 32'(cfg_if.cfg_pend), 32'h0);
        goto(t + 30);
        disarm(0);

        // Reset mid-operation discards pending writes and restores DIV_INIT
        r = t + 31;
        goto(r);
        cfg_write(4'd1, 16'd9);
        goto(r + 1);
        cfg_if.cfg_wr = 1'b0;
        chk("f_pend_pre", 32'(cfg_if.cfg_pend), 32'h2);
        goto(r + 3);
        rst = 1'b1;
        cfg_write(4'd2, 16'd0);
        goto(r + 4);
        cfg_if.cfg_wr = 1'b0;
        goto(r + 5);
        chk("f_rst_outclk", 32'(outclk), 32'h0);
        chk("f_rst_tick", 32'(tick), 32'h0);
        chk("f_rst_pend", 32'(cfg_if.cfg_pend), 32'h0);
        rst = 1'b0;
        armed = 4'hF;
        for (int c = 0; c < NCH; c++) push_edges(c, r + 9, 3, 2);
        goto(r + 22);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("left_ch%0d", c), 32'(exp_q[c].size()), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter DIVW, default 16: width of each channel's half-period divisor.
REQ-003 Parameter DIV_INIT, default 3: divisor loaded into every channel at reset (3 gives mclk/8).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 mclk  input  1  master clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 en  input  NCH  per-channel run enable.
REQ-008 sync  input  1  one-cycle strobe that restarts all channels phase-aligned.
REQ-009 cfg_wr  input  1  one-cycle divisor write strobe.
REQ-010 cfg_ch  input  4  channel index for cfg_wr.
REQ-011 cfg_div  input  DIVW  new half-period divisor D.
REQ-012 cfg_pend  output  NCH  per-channel flag: a written divisor is waiting to take effect.
REQ-013 outclk  output  NCH  divided clock per channel, registered.
REQ-014 tick  output  NCH  one-mclk-cycle pulse per channel at each outclk rising edge.

Function
REQ-015 Each channel SHALL hold cnt[DIVW], active divisor div_act, shadow divisor div_shd, pend flag and outclk register.
REQ-016 Enabled channel: if cnt==div_act then cnt<=0 and outclk toggles, else cnt<=cnt+1; output period is 2*(div_act+1) mclk cycles at 50% duty.
REQ-017 D=0 SHALL give mclk/2; D=2^DIVW-1 SHALL give period 2^(DIVW+1) with no counter overflow.
REQ-018 Disabled channel: cnt<=0 and outclk<=0 on the next edge; re-enable restarts with the low half-period.
REQ-019 cfg_wr with cfg_ch<NCH SHALL write div_shd[cfg_ch]<=cfg_div and set pend; cfg_ch>=NCH SHALL be ignored.
REQ-020 A pending divisor SHALL apply (div_act<=div_shd, pend<=0) only at the end of a full period (cnt==div_act while outclk==1) so that no runt pulse occurs, or immediately while the channel is disabled.
REQ-021 A second cfg_wr to a pending channel SHALL overwrite div_shd; only the last value applies.
REQ-022 cfg_wr on the same cycle as an apply to that channel: apply uses the old div_shd, the new value is captured, and pend stays 1.
REQ-023 sync SHALL set cnt<=0 and outclk<=0 on all channels and apply any pending divisor; sync has priority over normal counting.
REQ-024 cfg_wr coinciding with sync SHALL behave as REQ-022: the pre-existing shadow applies and the new value remains pending.
REQ-025 tick SHALL be registered and asserted in exactly the cycle outclk first reads 1 after a 0.
REQ-026 cfg_pend SHALL equal the internal pend flag.

Reset
REQ-027 rst SHALL set cnt=0, outclk=0, tick=0, pend=0, and div_act=div_shd=DIV_INIT on all channels; rst overrides every other input.
REQ-028 Reset asserted mid-period SHALL discard any pending write; the first outclk rise after release occurs DIV_INIT+1 cycles after the first enabled edge.

Configuration
REQ-029 Macro CLK_DIV_PROG_TICK_EN: when defined, tick is generated per REQ-025.
REQ-030 When CLK_DIV_PROG_TICK_EN is not defined, the tick logic SHALL be absent and the tick port SHALL be tied to all-zero.

Verification
REQ-031 Reset, en=4'b1111, default divisors -> each outclk period is 8 cycles at 50% duty; first rise 4 cycles after the first enabled edge.
REQ-032 cfg_wr ch1 D=0 mid-high-phase -> cfg_pend[1]=1 until the current period ends; then outclk[1] is mclk/2 and no pulse is shorter than 1 cycle.
REQ-033 Writes ch2 D=5 then D=9 before the boundary -> only D=9 applies (period 20); D=5 is never observed.
REQ-034 Channels with D=1/3/7 running, sync pulse -> all outclk are 0 on the next cycle; ch0 (D=1) rises 2 cycles later and ch1 (D=3) rises 4 cycles later.
REQ-035 cfg_wr ch0 D=2 on the same cycle as sync, with an older pending D=4 -> D=4 applies at sync, D=2 stays pending and applies at the next period end.
REQ-036 rst asserted mid-operation with pending writes -> all outputs 0, cfg_pend=0, divisors back to DIV_INIT; tick has exactly one pulse per outclk rise (tick stays 0 without the macro).
